// File: rtl/fibo_seq_ctrl.sv
// Fibonacci sequencing controller: streams terms over valid/ready.
// Optional FIBO_WRAP_EN: terms wrap instead of stopping on overflow.
module fibo_seq_ctrl #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [CNT_W-1:0] num_terms,
  input  logic             abort,
  input  logic             term_ready,
  output logic             term_valid,
  output logic [WIDTH-1:0] term_data,
  output logic [CNT_W-1:0] term_idx,
  output logic             busy,
  output logic             done,
  output logic             ovf
);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             a_ov;
  logic [CNT_W-1:0] idx;
  logic [CNT_W-1:0] count;
  logic             ovf_q;
  logic [WIDTH:0]   sum;
  logic             xfer;
  logic             last;
  logic             stop;
  logic             fin;

  assign sum  = {1'b0, a} + {1'b0, b};
  assign xfer = (state == RUN) && term_ready && !abort;
  assign last = (idx + CNT_W'(1)) == count;
`ifdef FIBO_WRAP_EN
  assign stop = 1'b0;
`else
  assign stop = a_ov;
`endif
  assign fin  = last || stop;

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic; abort wins over a same-cycle transfer
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: begin
        if (start)
          state_nxt = (num_terms != '0) ? RUN : DONE;
      end
      RUN: begin
        if (abort)
          state_nxt = IDLE;
        else if (term_ready && fin)
          state_nxt = DONE;
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Term datapath; idx is frozen on the final transfer
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      a     <= WIDTH'(1);
      b     <= '0;
      a_ov  <= 1'b0;
      idx   <= '0;
      count <= '0;
      ovf_q <= 1'b0;
    end else if (state == IDLE && start) begin
      a     <= WIDTH'(1);
      b     <= '0;
      a_ov  <= 1'b0;
      idx   <= '0;
      count <= num_terms;
      ovf_q <= 1'b0;
    end else if (xfer) begin
      ovf_q <= ovf_q | a_ov;
      if (!fin) begin
        b    <= a;
        a    <= sum[WIDTH-1:0];
        a_ov <= a_ov | sum[WIDTH];
        idx  <= idx + CNT_W'(1);
      end
    end
  end

  assign term_valid = (state == RUN);
  assign term_data  = term_valid ? b : '0;
  assign term_idx   = idx;
  assign busy       = (state != IDLE);
  assign done       = (state == DONE) && !abort;
  assign ovf        = ovf_q;

endmodule

// File: tb/tb_fibo_seq_ctrl.sv
// Scoreboard bench for fibo_seq_ctrl.
// Expected terms/done queued by stimulus, checked by a monitor.
module tb_fibo_seq_ctrl;

  localparam int WIDTH = 4;
  localparam int CNT_W = 5;

  logic             clk = 1'b0;
  logic             reset;
  logic             start;
  logic [CNT_W-1:0] num_terms;
  logic             abort;
  logic             term_ready;
  logic             term_valid;
  logic [WIDTH-1:0] term_data;
  logic [CNT_W-1:0] term_idx;
  logic             busy;
  logic             done;
  logic             ovf;

  int checks = 0;
  int failures = 0;

  typedef struct {
    int d;
    int i;
  } term_t;

  term_t term_q[$];
  int    done_q[$];

  fibo_seq_ctrl #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk(clk),
    .reset(reset),
    .start(start),
    .num_terms(num_terms),
    .abort(abort),
    .term_ready(term_ready),
    .term_valid(term_valid),
    .term_data(term_data),
    .term_idx(term_idx),
    .busy(busy),
    .done(done),
    .ovf(ovf)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  // Monitor: pops expectations whenever the DUT presents a term or done
  logic             have_stall = 1'b0;
  logic [WIDTH-1:0] last_d;
  logic [CNT_W-1:0] last_i;
  always @(negedge clk) begin
    if (!reset) begin
      have_stall = 1'b0;
    end else begin
      if (have_stall && term_valid) begin
        check("stall_data", term_data, last_d);
        check("stall_idx", term_idx, last_i);
      end
      if (term_valid && term_ready && !abort) begin
        if (term_q.size() == 0) begin
          check("unexpected_term", 1, 0);
        end else begin
          term_t t;
          t = term_q.pop_front();
          check("term_data", term_data, t.d);
          check("term_idx", term_idx, t.i);
        end
      end
      if (!term_valid)
        check("data_zero_idle", term_data, 0);
      if (done) begin
        check("done_valid_low", term_valid, 0);
        check("done_busy", busy, 1);
        if (done_q.size() == 0) check("unexpected_done", 1, 0);
        else check("done_ovf", ovf, done_q.pop_front());
      end
      have_stall = term_valid && !term_ready && !abort;
      last_d = term_data;
      last_i = term_idx;
    end
  end

  task automatic push_terms(input int n, input int vals[]);
    for (int k = 0; k < n; k++) begin
      term_t t;
      t.d = vals[k];
      t.i = k;
      term_q.push_back(t);
    end
  endtask

  task automatic issue(input int n);
    @(posedge clk); #1;
    start = 1'b1;
    num_terms = CNT_W'(n);
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  // Waits for busy to fall; optional ready toggling and start injection
  task automatic wait_idle(input bit toggle, input bit inject);
    bit ok;
    ok = 1'b0;
    for (int c = 0; c < 200; c++) begin
      if (!busy) begin
        ok = 1'b1;
        break;
      end
      if (toggle) term_ready = ((c % 4) == 0) || ((c % 4) == 3);
      start = inject && (c == 2);
      num_terms = inject && (c == 2) ? CNT_W'(7) : num_terms;
      @(posedge clk); #1;
    end
    start = 1'b0;
    term_ready = 1'b1;
    check("wait_idle_timeout", ok, 1);
  endtask

  initial begin
    int seq6[] = '{0, 1, 1, 2, 3, 5};
    int seq10[] = '{0, 1, 1, 2, 3, 5, 8, 13, 5, 2};
    int seq4[] = '{0, 1, 1, 2};
    bit seen;

    reset = 1'b0;
    start = 1'b0;
    num_terms = '0;
    abort = 1'b0;
    term_ready = 1'b1;
    #3;
    check("rst_valid", term_valid, 0);
    check("rst_data", term_data, 0);
    check("rst_idx", term_idx, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_ovf", ovf, 0);
    #10 reset = 1'b1;

    // Async reset mid-run
    push_terms(6, seq6);
    issue(6);
    @(posedge clk); #2;
    reset = 1'b0;
    #1;
    check("mid_rst_valid", term_valid, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_idx", term_idx, 0);
    check("mid_rst_data", term_data, 0);
    term_q.delete();
    done_q.delete();
    #3 reset = 1'b1;

    // Plain six-term run
    push_terms(6, seq6);
    done_q.push_back(0);
    issue(6);
    wait_idle(1'b0, 1'b0);
    check("seq6_ovf", ovf, 0);

    // Ten-term request crossing overflow
`ifdef FIBO_WRAP_EN
    push_terms(10, seq10);
`else
    push_terms(8, seq10);
`endif
    done_q.push_back(1);
    issue(10);
    wait_idle(1'b0, 1'b0);
    check("seq10_ovf", ovf, 1);

    // Stalled consumer, start during RUN ignored
    push_terms(4, seq4);
    done_q.push_back(0);
    issue(4);
    wait_idle(1'b1, 1'b1);
    check("stall_ovf", ovf, 0);

    // Abort while idx 3 is presented
    push_terms(3, seq6);
    issue(6);
    seen = 1'b0;
    for (int c = 0; c < 50; c++) begin
      if (term_idx == CNT_W'(3) && term_valid) begin
        seen = 1'b1;
        break;
      end
      @(posedge clk); #1;
    end
    check("abort_reach_idx3", seen, 1);
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    check("abort_busy", busy, 0);
    check("abort_done", done, 0);

    // Zero-length request
    done_q.push_back(0);
    issue(0);
    wait_idle(1'b0, 1'b0);
    check("zero_ovf", ovf, 0);

    repeat (3) @(posedge clk);
    #1;
    check("term_q_empty", term_q.size(), 0);
    check("done_q_empty", done_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
